delay_line: RTL and testbench

DELAY_LINE -- requirements
Module: delay_line

---
 rtl/delay_line.sv | 45 ++++
 tb/tb_delay_line.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/delay_line.sv
// delay_line: ce-gated tapped delay line with selectable depth, flush and fill tracking
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             flush,
  input  logic [SW-1:0]    sel,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             primed
);
  logic [WIDTH-1:0] d [1:DEPTH];
  logic [DEPTH:1]   v;
  logic [SW-1:0]    fill;
  logic [SW-1:0]    eff_sel;
  assign eff_sel    = (sel == '0) ? SW'(1) : (sel > SW'(DEPTH)) ? SW'(DEPTH) : sel;
  assign dout       = d[eff_sel];
  assign dout_valid = v[eff_sel];
  assign primed     = fill >= eff_sel;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) d[k] <= '0;
      v    <= '0;
      fill <= '0;
    end else if (flush) begin
      for (int k = 1; k <= DEPTH; k++) d[k] <= '0;
      v    <= '0;
      fill <= '0;
    end else if (ce) begin
      d[1] <= din;
      v[1] <= din_valid;
      for (int k = 2; k <= DEPTH; k++) begin
        d[k] <= d[k-1];
        v[k] <= v[k-1];
      end
      fill <= (fill == SW'(DEPTH)) ? fill : fill + SW'(1);
    end
  end
endmodule

// File: tb/tb_delay_line.sv
// tb_delay_line: directed checks of delay, stall, clamp, flush, async reset and live sel
module tb_delay_line;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] sel = 3'd1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       primed;
  int checks = 0;
  int errors = 0;

  delay_line #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .sel(sel),
    .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; ce = 1'b0; tick(); flush = 1'b0;
  endtask

  task automatic push(input logic [7:0] val, input logic vld);
    ce = 1'b1; din = val; din_valid = vld; tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    checks++; if (primed !== 1'b0) begin errors++; $display("FAIL reset_primed: got %b expected 0", primed); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    sel = 3'd3;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    checks++; if (dout_valid !== 1'b0 || primed !== 1'b0) begin errors++; $display("FAIL basic_edge2: got valid=%b primed=%b expected 0 0", dout_valid, primed); end
    push(8'h33, 1'b1);
    checks++; if (dout !== 8'h11 || dout_valid !== 1'b1) begin errors++; $display("FAIL basic_edge3: got %h/%b expected 11/1", dout, dout_valid); end
    checks++; if (primed !== 1'b1) begin errors++; $display("FAIL basic_primed: got %b expected 1", primed); end
    push(8'h44, 1'b1);
    checks++; if (dout !== 8'h22) begin errors++; $display("FAIL basic_edge4: got %h expected 22", dout); end
  endtask

  task automatic test_stall();
    do_flush();
    sel = 3'd2;
    push(8'hA5, 1'b1);
    ce = 1'b0; din = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dout_valid !== 1'b0 || primed !== 1'b0) begin errors++; $display("FAIL stall_hold_empty: got valid=%b primed=%b expected 0 0", dout_valid, primed); end
    end
    push(8'h00, 1'b0);
    checks++; if (dout !== 8'hA5 || dout_valid !== 1'b1 || primed !== 1'b1) begin errors++; $display("FAIL stall_release: got %h/%b/%b expected a5/1/1", dout, dout_valid, primed); end
    ce = 1'b0; din = 8'hEE; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dout !== 8'hA5 || dout_valid !== 1'b1) begin errors++; $display("FAIL stall_stable: got %h/%b expected a5/1", dout, dout_valid); end
    end
  endtask

  task automatic test_clamp();
    do_flush();
    sel = 3'd0;
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    checks++; if (dout !== 8'h05) begin errors++; $display("FAIL clamp_sel0_e5: got %h expected 05", dout); end
    push(8'h06, 1'b1);
    checks++; if (dout !== 8'h06) begin errors++; $display("FAIL clamp_sel0_e6: got %h expected 06", dout); end
    sel = 3'd7; #1;
    checks++; if (dout !== 8'h03) begin errors++; $display("FAIL clamp_sel7: got %h expected 03", dout); end
    sel = 3'd5; #1;
    checks++; if (dout !== 8'h03) begin errors++; $display("FAIL clamp_sel5: got %h expected 03", dout); end
    sel = 3'd4;
    for (int i = 0; i < 6; i++) push(8'h00, 1'b0);
    checks++; if (primed !== 1'b1) begin errors++; $display("FAIL fill_saturate: got %b expected 1", primed); end
  endtask

  task automatic test_flush();
    do_flush();
    sel = 3'd4;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b1);
    checks++; if (dout !== 8'h10 || primed !== 1'b1) begin errors++; $display("FAIL flush_fill: got %h/%b expected 10/1", dout, primed); end
    flush = 1'b1; ce = 1'b1; din = 8'hFF; din_valid = 1'b1; tick();
    flush = 1'b0; ce = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      sel = 3'(s); #1;
      checks++; if (dout !== 8'h00 || dout_valid !== 1'b0 || primed !== 1'b0) begin errors++; $display("FAIL flush_sel%0d: got %h/%b/%b expected 00/0/0", s, dout, dout_valid, primed); end
    end
    push(8'h00, 1'b0);
    sel = 3'd2; #1;
    checks++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ff: got %h/%b expected 00/0", dout, dout_valid); end
  endtask

  task automatic test_async_reset();
    do_flush();
    sel = 3'd4;
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 1'b1);
    ce = 1'b0;
    #3 rst_n = 1'b0; #1;
    checks++; if (dout !== 8'h00 || dout_valid !== 1'b0 || primed !== 1'b0) begin errors++; $display("FAIL async_reset: got %h/%b/%b expected 00/0/0", dout, dout_valid, primed); end
    tick();
    @(negedge clk); rst_n = 1'b1;
    push(8'h77, 1'b1);
    for (int i = 2; i <= 3; i++) begin
      push(8'h00, 1'b0);
      checks++; if (dout_valid !== 1'b0 || primed !== 1'b0) begin errors++; $display("FAIL async_refill_e%0d: got %b/%b expected 0/0", i, dout_valid, primed); end
    end
    push(8'h00, 1'b0);
    checks++; if (dout !== 8'h77 || dout_valid !== 1'b1 || primed !== 1'b1) begin errors++; $display("FAIL async_refill_e4: got %h/%b/%b expected 77/1/1", dout, dout_valid, primed); end
  endtask

  task automatic test_live_sel();
    do_flush();
    sel = 3'd4;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 1'b1);
    ce = 1'b0;
    checks++; if (dout !== 8'h40) begin errors++; $display("FAIL live_sel4: got %h expected 40", dout); end
    sel = 3'd1; #1;
    checks++; if (dout !== 8'h43 || primed !== 1'b1) begin errors++; $display("FAIL live_sel1: got %h/%b expected 43/1", dout, primed); end
    sel = 3'd2; #1;
    checks++; if (dout !== 8'h42 || dout_valid !== 1'b1) begin errors++; $display("FAIL live_sel2: got %h/%b expected 42/1", dout, dout_valid); end
    sel = 3'd4; #1;
    checks++; if (dout !== 8'h40) begin errors++; $display("FAIL live_sel_back: got %h expected 40", dout); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_clamp();
    test_flush();
    test_async_reset();
    test_live_sel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
